// File: rtl/coriolis_pkg.sv
// Shared definitions for the coriolis kernel datapath.
//
// STREAMW       : width of one stream word (32-bit FP payload plus the
//                 2-bit flopoco exception field in the top bits).
// FP_EXC_NORMAL : flopoco exception code for an ordinary finite number.
// obuf_op_e     : per-cycle buffer operation, encoded as {push, pop} so the
//                 control logic can cast the two strobes straight into it.
package coriolis_pkg;

    localparam int STREAMW = 34;

    localparam logic [1:0] FP_EXC_NORMAL = 2'b01;

    typedef enum logic [1:0] {
        OBUF_IDLE = 2'b00,
        OBUF_POP  = 2'b01,
        OBUF_PUSH = 2'b10,
        OBUF_BOTH = 2'b11
    } obuf_op_e;

endpackage : coriolis_pkg

// File: rtl/coriolis_ker0_obuf_ram.sv
// Storage array for the ker0 output buffer.
//
// DEPTH x W register array with one synchronous write port and one
// asynchronous read port. The contents are deliberately not reset: the
// valid/occupancy state in the parent decides which entries are meaningful.
//
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module coriolis_ker0_obuf_ram #(
    parameter int W     = 34,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : coriolis_ker0_obuf_ram

// File: rtl/coriolis_ker0_obuf.sv
// Elastic output buffer behind the fixed-latency ker0 leaf node.
//
// First-word-fall-through FIFO that absorbs results still in flight in the
// upstream pipeline when the consumer stalls. iready is a slack-adjusted
// "space available" hint: it drops while SLACK or fewer entries are free so
// that up to SLACK words already launched upstream can still land. Writes are
// never gated by iready; only a truly full buffer rejects a word, and doing
// so sets the sticky ovf error flag.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   ivalid   in   upstream word valid
//   in1_s0   in   upstream word
//   iready   out  registered, (DEPTH - occupancy) > SLACK
//   ovalid   out  head entry valid (occupancy != 0)
//   out1_s0  out  head entry, forced to zero while empty
//   oready   in   downstream accepts head entry
//   count    out  occupancy, 0..DEPTH
//   ovf      out  sticky overflow, cleared only by reset
//
// DEPTH must be a power of two >= 2, and SLACK must be below DEPTH.
module coriolis_ker0_obuf #(
    parameter int STREAMW = coriolis_pkg::STREAMW,
    parameter int DEPTH   = 8,
    parameter int SLACK   = 3,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               iready,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1_s0,
    input  logic               oready,
    output logic [AW:0]        count,
    output logic               ovf
);

    import coriolis_pkg::*;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] SLACK_C = (AW+1)'(SLACK);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic               iready_q;
    logic               iready_d;
    logic               ovf_q;
    logic               full;
    logic               push;
    logic               pop;
    logic [STREAMW-1:0] rd_data;
    obuf_op_e           op;

    // Full is judged on the registered occupancy, so a pop in the same cycle
    // does not make room for a write arriving while full.
    assign full = (count_q == DEPTH_C);
    assign push = ivalid && !full;
    assign pop  = (count_q != '0) && oready;

    always_comb begin
        op      = obuf_op_e'({push, pop});
        count_d = count_q;
        unique case (op)
            OBUF_PUSH: count_d = count_q + (AW+1)'(1);
            OBUF_POP:  count_d = count_q - (AW+1)'(1);
            default:   count_d = count_q;
        endcase
    end

    // Registered ready looks at the post-edge occupancy so it is exact in the
    // cycle it is presented.
    always_comb begin
        iready_d = (DEPTH_C - count_d) > SLACK_C;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            iready_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q  <= count_d;
            iready_q <= iready_d;
            if (ivalid && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    coriolis_ker0_obuf_ram #(
        .W     (STREAMW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in1_s0),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // The array is not reset, so the head is masked while empty; this keeps
    // out1_s0 at zero during and after reset without clearing storage.
    assign ovalid  = (count_q != '0);
    assign out1_s0 = ovalid ? rd_data : '0;
    assign iready  = iready_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule : coriolis_ker0_obuf

// File: tb/tb_coriolis_ker0_obuf.sv
module tb_coriolis_ker0_obuf;

    localparam int W = 34;

    logic         clk;
    logic         rst;
    logic         ivalid;
    logic [W-1:0] in1_s0;
    logic         iready;
    logic         ovalid;
    logic [W-1:0] out1_s0;
    logic         oready;
    logic [3:0]   count;
    logic         ovf;

    int           n_cmp = 0;
    int           n_err = 0;
    int           mcount = 0;
    logic [W-1:0] exp_q[$];

    coriolis_ker0_obuf #(
        .STREAMW (W),
        .DEPTH   (8),
        .SLACK   (3),
        .AW      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .in1_s0  (in1_s0),
        .iready  (iready),
        .ovalid  (ovalid),
        .out1_s0 (out1_s0),
        .oready  (oready),
        .count   (count),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: a pop happens at the next rising edge whenever
    // ovalid and oready are both high in the second half of the cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && ovalid === 1'b1 && oready === 1'b1) begin
            logic [W-1:0] exp_w;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_pop: unexpected output %h, scoreboard empty", out1_s0);
            end else begin
                exp_w = exp_q.pop_front();
                if (out1_s0 !== exp_w) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", out1_s0, exp_w);
                end
            end
        end
    end

    // One clock of stimulus; updates the reference occupancy and queue.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
        logic do_push;
        logic do_pop;
        ivalid  = iv;
        in1_s0  = d;
        oready  = ordy;
        do_push = iv && (mcount < 8);
        do_pop  = (mcount != 0) && ordy;
        if (do_push) exp_q.push_back(d);
        mcount = mcount + int'(do_push) - int'(do_pop);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b0;
        ivalid = 1'b0;
        in1_s0 = '0;
        oready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        mcount = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        ivalid = 1'b0;
        in1_s0 = '0;
        oready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b expected 1", iready); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_cmp++; if (out1_s0 !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out1_s0); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (iready !== 1'b1 || count !== 4'd0) begin
            n_err++; $display("FAIL reset_release: iready %b count %0d expected 1/0", iready, count);
        end
    endtask

    task automatic test_pass_through();
        logic [W-1:0] vals [3];
        vals[0] = 34'h0_3F800000;
        vals[1] = 34'h0_40000000;
        vals[2] = 34'h0_40400000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 1'b1);
            n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL pt_count: got %0d expected 1", count); end
            n_cmp++; if (ovalid !== 1'b1 || out1_s0 !== vals[i]) begin
                n_err++; $display("FAIL pt_head: got %b/%h expected 1/%h", ovalid, out1_s0, vals[i]);
            end
        end
        step(1'b0, '0, 1'b1);
        n_cmp++; if (count !== 4'd0 || ovalid !== 1'b0) begin
            n_err++; $display("FAIL pt_empty: count %0d ovalid %b expected 0/0", count, ovalid);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b0);
            n_cmp++; if (count !== 4'(i)) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", count, i); end
            n_cmp++; if (iready !== ((8 - i) > 3)) begin
                n_err++; $display("FAIL bp_iready: count %0d got %b expected %b", i, iready, (8 - i) > 3);
            end
            n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b expected 0", ovf); end
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++; if (count !== 4'(8 - i)) begin n_err++; $display("FAIL bp_drain: got %0d expected %0d", count, 8 - i); end
        end
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL bp_iready_empty: got %b expected 1", iready); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) step(1'b1, W'(32'h100 + i), 1'b0);
        step(1'b1, W'(32'hDEAD), 1'b0);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d expected 8", count); end
        // Full is judged before the pop: this word is dropped too.
        step(1'b1, W'(32'hBEEF), 1'b1);
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL ovf_norescue: got %0d expected 7", count); end
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
        // Extra pops while empty must not underflow.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++; if (count !== 4'd0 || ovalid !== 1'b0) begin
                n_err++; $display("FAIL underflow: count %0d ovalid %b expected 0/0", count, ovalid);
            end
        end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
        apply_reset();
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'h300 + i), 1'b0);
        // 30 simultaneous push/pop cycles run the pointers round several times.
        for (int i = 0; i < 30; i++) begin
            step(1'b1, {2'b01, 32'h3F80_0000 + 32'(i)}, 1'b1);
            n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL b2b_count: cycle %0d got %0d expected 4", i, count); end
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL b2b_drain: got %0d expected 0", count); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) step(1'b1, W'(32'h500 + i), 1'b0);
        n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL mr_fill: got %0d expected 6", count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mr_count: got %0d expected 0", count); end
        n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL mr_ovalid: got %b expected 0", ovalid); end
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL mr_iready: got %b expected 1", iready); end
        n_cmp++; if (out1_s0 !== '0) begin n_err++; $display("FAIL mr_data: got %h expected 0", out1_s0); end
        exp_q.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, W'(32'h42), 1'b1);
        n_cmp++; if (ovalid !== 1'b1 || out1_s0 !== W'(32'h42)) begin
            n_err++; $display("FAIL mr_next: got %b/%h expected 1/42", ovalid, out1_s0);
        end
        step(1'b0, '0, 1'b1);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mr_drain: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_coriolis_ker0_obuf

// File: doc/coriolis_ker0_obuf.md
Name: coriolis_ker0_obuf

Overview:
- Elastic output buffer placed directly downstream of a fixed-latency kernel leaf node, such as the ker0 FP multiply stage.
- Absorbs in-flight results when the consumer back-pressures, so the upstream pipeline can drain without loss.
- Synchronous first-word-fall-through (FWFT) FIFO with a slack-based ready, an occupancy count and a sticky overflow flag.

Parameters:
- STREAMW, 34, data width: FP payload plus the 2-bit flopoco exception field.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- SLACK, 3, upstream pipeline latency; iready drops when free entries <= SLACK.
- AW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ivalid  in  1  upstream data valid.
- in1_s0  in  STREAMW  upstream data.
- iready  out  1  space available, slack-adjusted.
- ovalid  out  1  head entry valid.
- out1_s0  out  STREAMW  head entry data (FWFT).
- oready  in  1  downstream accepts.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow error.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovalid=0, iready=1, ovf=0, out1_s0=0. Storage array is not reset.
- Push occurs when ivalid=1 and count<DEPTH. The push is not gated by iready, so upstream in-flight data is still accepted.
- Pop occurs when ovalid=1 and oready=1.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - With count=0, push and pop cannot coincide because ovalid=0.
- Pointers wrap modulo DEPTH.
- count is registered: +1 on push only, -1 on pop only.
- ovalid = (count!=0).
- out1_s0 = mem[rd_ptr], combinational from a registered pointer.
- Write latency: data pushed at edge N is visible at out1_s0 with ovalid=1 after edge N (one cycle).
- iready is registered and updates each edge to (DEPTH - count_next) > SLACK.
- ivalid=1 while count==DEPTH:
  - data is dropped;
  - ovf sets to 1 and stays set until reset;
  - pointers and count are unchanged.
  - A same-cycle pop does not rescue the write; full is evaluated before the pop.
- oready=1 with count=0: no effect and no underflow.
- Reset asserted mid-transfer: all state clears immediately and stored data is discarded. Outputs follow the reset values above while rst=0.
- Release of reset is synchronized externally; the block only assumes release is glitch-free.

Decomposition:
- Shared package coriolis_pkg holds STREAMW and the FP_EXC_NORMAL constant (2'b01).
- Optional sub-module coriolis_ker0_obuf_ram: DEPTH x STREAMW register array with one write port and one asynchronous read port.
- Control logic (pointers, count, flags) stays in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release.
  - Expect ovalid=0, iready=1, count=0, ovf=0, out1_s0=0.
- Pass-through: oready=1; push 0x0_3F800000, 0x0_40000000, 0x0_40400000 on consecutive cycles.
  - Each value appears on out1_s0 one cycle after its push, in order.
  - count never exceeds 1.
- Back-pressure fill: oready=0; push 8 words 0x1..0x8.
  - iready falls after count reaches 5 (DEPTH-SLACK).
  - count reaches 8; ovf stays 0.
  - Then oready=1 drains 0x1..0x8 in order over 8 cycles, and count returns to 0.
- Overflow: with count=8 and oready=0, push 0xDEAD.
  - Expect ovf=1, count=8, 0xDEAD never output.
  - ovf stays 1 after the drain and clears only on reset.
- Simultaneous push and pop:
  - At count=4, ivalid=1 and oready=1 for 10 cycles: count stays 4, order preserved.
  - Cross the wrap-around by running 20 words through the buffer.
- Mid-operation reset: at count=6, assert rst=0 for 1 cycle.
  - count=0, ovalid=0 and iready=1 take effect immediately, without waiting for a clock edge.
  - A subsequent push of 0x42 is the next word output.
